mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit; sequential companion to the single-cycle integer ALU in the EX stage.

---
 rtl/mul_div_pkg.sv | 31 +++
 rtl/mul_div_datapath.sv | 81 ++++++++
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit and its EX-stage neighbours.
// Op encoding follows the RV32M funct3 field, so bit 2 set means a divide-class op.
package mul_div_pkg;

  localparam int XLEN           = 32;
  localparam int MULDIV_LATENCY = XLEN + 1;

  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mul_div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(input mul_div_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Radix-2 shift-add multiplier / restoring divider on unsigned magnitudes.
// hi holds product-high or partial remainder; lo holds multiplier bits or quotient bits.
module mul_div_datapath
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step,
  input  logic                  i_is_div,
  input  logic [DATA_WIDTH-1:0] i_a_mag,
  input  logic [DATA_WIDTH-1:0] i_b_mag,
  output logic [DATA_WIDTH-1:0] o_hi_next,
  output logic [DATA_WIDTH-1:0] o_lo_next,
  output logic [CW-1:0]         o_count
);

  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  div_q, div_d;
  logic [DATA_WIDTH:0]   sum, shifted;
  logic [DATA_WIDTH+1:0] diff;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    count_d = count_q;
    div_d   = div_q;
    sum     = {1'b0, hi_q} + {1'b0, opnd_q};
    shifted = {hi_q, lo_q[DATA_WIDTH-1]};
    // one extra bit so a shifted remainder >= 2^W cannot be mistaken for a borrow
    diff    = {1'b0, shifted} - {2'b00, opnd_q};
    if (i_start) begin
      hi_d    = '0;
      lo_d    = i_is_div ? i_a_mag : i_b_mag;
      opnd_d  = i_is_div ? i_b_mag : i_a_mag;
      count_d = '0;
      div_d   = i_is_div;
    end else if (i_step) begin
      count_d = count_q + CW'(1);
      if (div_q) begin
        if (!diff[DATA_WIDTH+1]) begin
          hi_d = diff[DATA_WIDTH-1:0];
          lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[DATA_WIDTH-1:0];
          lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        {hi_d, lo_d} = {sum, lo_q[DATA_WIDTH-1:1]};
      end else begin
        {hi_d, lo_d} = {1'b0, hi_q, lo_q[DATA_WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      count_q <= '0;
      div_q   <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      count_q <= count_d;
      div_q   <= div_d;
    end
  end

  assign o_hi_next = hi_d;
  assign o_lo_next = lo_d;
  assign o_count   = count_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: handshake FSM, sign handling and special cases around
// an unsigned shift/add/subtract core. Result is registered and held until consumed.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit FAST_ZERO  = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  mul_div_op_e           i_op,
  input  logic [DATA_WIDTH-1:0] i_operandA,
  input  logic [DATA_WIDTH-1:0] i_operandB,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                  state_q, state_d;
  mul_div_op_e             op_q, op_d;
  logic                    neg_q, neg_d, special_q, special_d;
  logic [DATA_WIDTH-1:0]   special_val_q, special_val_d, result_q, result_d;
  logic                    a_signed, b_signed, sign_a, sign_b, neg_in;
  logic                    div_zero, overflow, special_in;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag, special_val_in, core_result;
  logic [2*DATA_WIDTH-1:0] prod_raw, prod_fix;
  logic                    dp_start, dp_step;
  logic [DATA_WIDTH-1:0]   dp_hi_next, dp_lo_next;
  logic [CW-1:0]           dp_count;

  // Operand decode for the request currently presented
  always_comb begin
    a_signed = 1'b1;
    b_signed = 1'b1;
    case (i_op)
      OP_MULHSU:                  b_signed = 1'b0;
      OP_MULHU, OP_DIVU, OP_REMU: begin a_signed = 1'b0; b_signed = 1'b0; end
      default:                    ;
    endcase
    sign_a     = a_signed & i_operandA[DATA_WIDTH-1];
    sign_b     = b_signed & i_operandB[DATA_WIDTH-1];
    a_mag      = sign_a ? -i_operandA : i_operandA;
    b_mag      = sign_b ? -i_operandB : i_operandB;
    neg_in     = (i_op == OP_REM || i_op == OP_REMU) ? sign_a : (sign_a ^ sign_b);
    div_zero   = op_is_div(i_op) && (i_operandB == '0);
    overflow   = (i_op == OP_DIV || i_op == OP_REM) && (i_operandA == MOST_NEG) && (i_operandB == '1);
    special_in = div_zero | overflow;
    special_val_in = '0;
    if (div_zero)
      special_val_in = (i_op == OP_DIV || i_op == OP_DIVU) ? '1 : i_operandA;
    else if (overflow)
      special_val_in = (i_op == OP_DIV) ? i_operandA : '0;
  end

  // Final result formatting uses the values the datapath is loading on its last step
  always_comb begin
    prod_raw = {dp_hi_next, dp_lo_next};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: core_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:              core_result = neg_q ? -dp_lo_next : dp_lo_next;
      OP_REM, OP_REMU:              core_result = neg_q ? -dp_hi_next : dp_hi_next;
      default:                      core_result = prod_fix[DATA_WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    neg_d         = neg_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    result_d      = result_q;
    dp_start      = 1'b0;
    dp_step       = 1'b0;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (i_valid) begin
          op_d          = i_op;
          neg_d         = neg_in;
          special_d     = special_in;
          special_val_d = special_val_in;
          if (FAST_ZERO && special_in) begin
            state_d  = ST_DONE;
            result_d = special_val_in;
          end else begin
            state_d  = ST_BUSY;
            dp_start = 1'b1;
          end
        end
        ST_BUSY: begin
          dp_step = 1'b1;
          if (dp_count == CW'(DATA_WIDTH-1)) begin
            state_d  = ST_DONE;
            result_d = special_q ? special_val_q : core_result;
          end
        end
        ST_DONE: if (i_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_MUL;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      neg_q         <= neg_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      result_q      <= result_d;
    end
  end

  mul_div_datapath #(.DATA_WIDTH(DATA_WIDTH), .CW(CW)) u_datapath (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_start   (dp_start),
    .i_step    (dp_step),
    .i_is_div  (op_is_div(i_op)),
    .i_a_mag   (a_mag),
    .i_b_mag   (b_mag),
    .o_hi_next (dp_hi_next),
    .o_lo_next (dp_lo_next),
    .o_count   (dp_count)
  );

  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed scenarios on a 32-bit fast-path instance plus
// randomized comparison against an arithmetic reference on 32-bit and 8-bit (full-iteration) instances.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        flush = 1'b0, valid = 1'b0, rdy_in = 1'b1;
  mul_div_op_e op = OP_MUL;
  logic [31:0] a = '0, b = '0;
  logic        ready_o, valid_o;
  logic [31:0] res_o;

  logic        flush8 = 1'b0, valid8 = 1'b0, rdy8 = 1'b1;
  mul_div_op_e op8 = OP_MUL;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8_o, valid8_o;
  logic [7:0]  res8_o;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.DATA_WIDTH(32), .FAST_ZERO(1'b1)) dut (
    .i_clock(clk), .i_reset(rst), .i_flush(flush), .i_valid(valid), .o_ready(ready_o),
    .i_op(op), .i_operandA(a), .i_operandB(b), .o_valid(valid_o), .i_ready(rdy_in), .o_result(res_o)
  );

  mul_div_unit #(.DATA_WIDTH(8), .FAST_ZERO(1'b0)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_flush(flush8), .i_valid(valid8), .o_ready(ready8_o),
    .i_op(op8), .i_operandA(a8), .i_operandB(b8), .o_valid(valid8_o), .i_ready(rdy8), .o_result(res8_o)
  );

  // Reference built from native signed/unsigned arithmetic on w-bit operands
  function automatic logic [63:0] model(input int w, input mul_div_op_e o, input logic [63:0] x, input logic [63:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] mask, r;
    mask = (64'd1 << w) - 64'd1;
    ux = longint'(x & mask);
    uy = longint'(y & mask);
    sx = x[w-1] ? ux - (longint'(1) << w) : ux;
    sy = y[w-1] ? uy - (longint'(1) << w) : uy;
    case (o)
      OP_MULH:   r = (64'(sx * sy) >> w) & mask;
      OP_MULHSU: r = (64'(sx * uy) >> w) & mask;
      OP_MULHU:  r = (64'(ux * uy) >> w) & mask;
      OP_DIV:    r = (uy == 0) ? mask : ((sx == -(longint'(1) << (w-1)) && sy == -1) ? 64'(ux) : 64'(sx / sy) & mask);
      OP_DIVU:   r = (uy == 0) ? mask : 64'(ux / uy);
      OP_REM:    r = (uy == 0) ? 64'(ux) : ((sx == -(longint'(1) << (w-1)) && sy == -1) ? 64'd0 : 64'(sx % sy) & mask);
      OP_REMU:   r = (uy == 0) ? 64'(ux) : 64'(ux % uy);
      default:   r = 64'(sx * sy) & mask;
    endcase
    return r;
  endfunction

  // Issue one request at a negedge in IDLE; return at the negedge where o_valid is seen
  task automatic run32(input mul_div_op_e o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat);
    valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); lat = 1;
    @(negedge clk); valid = 1'b0; a = $urandom; b = $urandom;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    r = res_o;
    $display("[%0t] w32 %s a=%h b=%h -> %h lat=%0d", $time, o.name(), x, y, r, lat);
  endtask

  task automatic run8(input mul_div_op_e o, input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] r, output int lat);
    valid8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); lat = 1;
    @(negedge clk); valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (valid8_o !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    r = res8_o;
    $display("[%0t] w8 %s a=%h b=%h -> %h lat=%0d", $time, o.name(), x, y, r, lat);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int lat;
    #1 rst = 1'b1;
    #2;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    checks++; if (res_o !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=0", res_o); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk); valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_midbusy valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run32(OP_DIV, 32'hFFFFFF9C, 32'd7, r, lat);
    checks++; if (r !== 32'hFFFFFFF2) begin errors++; $display("FAIL reset_next_op got=%h want=fffffff2", r); end
    @(negedge clk);
  endtask

  task automatic test_mul_div();
    mul_div_op_e o;
    logic [31:0] x, y, e, r;
    int lat, want_lat;
    for (int i = 0; i < 10; i++) begin
      want_lat = MULDIV_LATENCY;
      case (i)
        0: begin o = OP_MUL;   x = 32'd7;        y = 32'hFFFFFFFD; e = 32'hFFFFFFEB; end
        1: begin o = OP_MULH;  x = 32'h80000000; y = 32'h80000000; e = 32'h40000000; end
        2: begin o = OP_MULHU; x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; e = 32'hFFFFFFFE; end
        3: begin o = OP_DIV;   x = 32'hFFFFFFF9; y = 32'd2;        e = 32'hFFFFFFFD; end
        4: begin o = OP_REM;   x = 32'hFFFFFFF9; y = 32'd2;        e = 32'hFFFFFFFF; end
        5: begin o = OP_DIVU;  x = 32'hFFFFFFF9; y = 32'd2;        e = 32'h7FFFFFFC; end
        6: begin o = OP_DIV;   x = 32'd5;        y = 32'd0;        e = 32'hFFFFFFFF; want_lat = 1; end
        7: begin o = OP_REMU;  x = 32'd5;        y = 32'd0;        e = 32'd5;        want_lat = 1; end
        8: begin o = OP_DIV;   x = 32'h80000000; y = 32'hFFFFFFFF; e = 32'h80000000; want_lat = 1; end
        default: begin o = OP_REM; x = 32'h80000000; y = 32'hFFFFFFFF; e = 32'd0;     want_lat = 1; end
      endcase
      run32(o, x, y, r, lat);
      checks++; if (r !== e) begin errors++; $display("FAIL directed_%0d result got=%h want=%h", i, r, e); end
      checks++; if (lat != want_lat) begin errors++; $display("FAIL directed_%0d latency got=%0d want=%0d", i, lat, want_lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    int lat;
    rdy_in = 1'b0;
    run32(OP_MULHU, 32'hFFFFFFFF, 32'd2, r, lat);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL bp_result got=%h want=1", r); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (valid_o !== 1'b1 || ready_o !== 1'b0 || res_o !== 32'd1) begin
        errors++; $display("FAIL bp_hold_%0d valid=%b ready=%b result=%h want 1/0/1", i, valid_o, ready_o, res_o);
      end
    end
    rdy_in = 1'b1;
    @(negedge clk);
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_release ready=%b valid=%b want 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r;
    int lat, seen;
    valid = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    @(negedge clk); valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1; valid = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd3;
    @(negedge clk); flush = 1'b0; valid = 1'b0;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_busy ready=%b valid=%b want 1/0", ready_o, valid_o);
    end
    seen = 0;
    repeat (40) begin @(negedge clk); if (valid_o === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_stale valid_cycles=%0d want=0", seen); end
    run32(OP_MULHSU, 32'hFFFFFFFF, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_next got=%h want=ffffffff", r); end
    @(negedge clk);
    run32(OP_DIVU, 32'd10, 32'd3, r, lat);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || r !== 32'd3) begin
      errors++; $display("FAIL flush_done ready=%b valid=%b result=%h want 1/0/3", ready_o, valid_o, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    run32(OP_MUL, 32'd12345, 32'd678, r, lat);
    checks++; if (ready_o !== 1'b0 || r !== 32'd8369910) begin
      errors++; $display("FAIL b2b_first ready=%b result=%h want 0/%h", ready_o, r, 32'd8369910);
    end
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL b2b_idle ready=%b want=1", ready_o); end
    run32(OP_REMU, 32'd1000, 32'd7, r, lat);
    checks++; if (r !== 32'd6) begin errors++; $display("FAIL b2b_second got=%h want=6", r); end
    @(negedge clk);
  endtask

  task automatic test_random32();
    mul_div_op_e o;
    logic [31:0] x, y, r, e;
    int lat, want_lat;
    bit special;
    for (int i = 0; i < 60; i++) begin
      o = mul_div_op_e'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: y = -32'($urandom_range(1, 20));
        default: ;
      endcase
      e = model(32, o, 64'(x), 64'(y))[31:0];
      special = (o >= OP_DIV) && (y == 0 || ((o == OP_DIV || o == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF));
      want_lat = special ? 1 : MULDIV_LATENCY;
      run32(o, x, y, r, lat);
      checks++; if (r !== e || lat != want_lat) begin
        errors++; $display("FAIL rand32_%0d %s a=%h b=%h got=%h lat=%0d want=%h lat=%0d", i, o.name(), x, y, r, lat, e, want_lat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random8();
    mul_div_op_e o;
    logic [7:0] x, y, r, e;
    int lat;
    for (int i = 0; i < 80; i++) begin
      o = mul_div_op_e'($urandom_range(0, 7));
      x = 8'($urandom); y = 8'($urandom);
      case ($urandom_range(0, 7))
        0: y = 8'd0;
        1: begin x = 8'h80; y = 8'hFF; end
        default: ;
      endcase
      e = model(8, o, 64'(x), 64'(y))[7:0];
      run8(o, x, y, r, lat);
      checks++; if (r !== e || lat != 9) begin
        errors++; $display("FAIL rand8_%0d %s a=%h b=%h got=%h lat=%0d want=%h lat=9", i, o.name(), x, y, r, lat, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul_div();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random32();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
